// File: rtl/core_insn_frame_loader.sv
// Per-core instruction frame loader: assembles scheduler parts into frames
// and queues them for the core pipeline. Optional macro: LOADER_PIPELINE_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   start, insn_load_counter, insn_data  - part stream from the scheduler
//   init_r0_en, init_r0                  - optional R0 init, latched at part 0
//   ready                                - to scheduler (~ready = busy)
//   frame_valid/ready/data/r0_load/r0    - FWFT head to the core pipeline
//   core_busy                            - core is executing a frame
//   err, err_clr                         - sticky [0] protocol, [1] overflow
//   frame_cnt                            - frames popped, mod 256
module core_insn_frame_loader #(
  parameter int INSN_LOAD_TIME = 4,
  parameter int PART_W         = 16,
  parameter int CNT_W          = 2,
  parameter int R0_W           = 8,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 insn_load_counter,
  input  logic [PART_W-1:0]                insn_data,
  input  logic                             init_r0_en,
  input  logic [R0_W-1:0]                  init_r0,
  output logic                             ready,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [PART_W*INSN_LOAD_TIME-1:0] frame_data,
  output logic                             frame_r0_load,
  output logic [R0_W-1:0]                  frame_r0,
  input  logic                             core_busy,
  output logic [1:0]                       err,
  input  logic                             err_clr,
  output logic [7:0]                       frame_cnt
);

  localparam int FW = PART_W * INSN_LOAD_TIME;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(INSN_LOAD_TIME - 1);
  localparam logic [PW:0] DEPTH =
    (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_M1 =
    (PW + 1)'(FIFO_DEPTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   exp_q;
  logic [CNT_W-1:0]   exp_d;
  logic [PART_W-1:0]  part_q [INSN_LOAD_TIME];
  logic               r0_pend_q;
  logic [R0_W-1:0]    r0_q;

  logic               cap;
  logic               push;
  logic               perr;
  logic               idle;
  logic [CNT_W-1:0]   idx;
  logic [FW-1:0]      frame_asm;
  logic               push_r0_load;
  logic [R0_W-1:0]    push_r0;

  logic [FW-1:0]      mem_d [FIFO_DEPTH];
  logic               mem_l [FIFO_DEPTH];
  logic [R0_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0]      rd_q;
  logic [PW-1:0]      wr_q;
  logic [PW:0]        cnt_q;
  logic               empty;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               ovf;
  logic [1:0]         err_q;
  logic [7:0]         fcnt_q;

  assign idle = (state_q == S_IDLE);
  assign idx  = idle ? '0 : exp_q;

  // Assembler: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  // Assembler: next state
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cap && !push) begin
          state_d = S_LOAD;
          exp_d   = CNT_W'(1);
        end
      end
      (state_q == S_LOAD): begin
        if (push || perr) begin
          state_d = S_IDLE;
        end else if (cap) begin
          exp_d = exp_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Assembler: outputs
  always_comb begin
    cap  = 1'b0;
    push = 1'b0;
    perr = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          if (insn_load_counter == '0) begin
            cap  = 1'b1;
            push = (LAST == '0);
          end else begin
            perr = 1'b1;
          end
        end
      end
      (state_q == S_LOAD): begin
        if (start && insn_load_counter == exp_q) begin
          cap  = 1'b1;
          push = (exp_q == LAST);
        end else begin
          perr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The part captured on the push edge bypasses the part registers
  always_comb begin
    frame_asm = '0;
    for (int i = 0; i < INSN_LOAD_TIME; i++) begin
      if (cap && idx == CNT_W'(i)) begin
        frame_asm[i*PART_W +: PART_W] = insn_data;
      end else begin
        frame_asm[i*PART_W +: PART_W] = part_q[i];
      end
    end
  end

  // Single-part frames push on part 0, so take R0 from the inputs
  assign push_r0_load = idle ? init_r0_en : r0_pend_q;
  assign push_r0      = idle ? init_r0 : r0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INSN_LOAD_TIME; i++) begin
        part_q[i] <= '0;
      end
      r0_pend_q <= 1'b0;
      r0_q      <= '0;
    end else begin
      for (int i = 0; i < INSN_LOAD_TIME; i++) begin
        if (cap && idx == CNT_W'(i)) begin
          part_q[i] <= insn_data;
        end
      end
      if (push || perr) begin
        r0_pend_q <= 1'b0;
      end else if (cap && idle) begin
        r0_pend_q <= init_r0_en;
      end
      if (cap && idle && init_r0_en) begin
        r0_q <= init_r0;
      end
    end
  end

  // FIFO
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH);
  assign pop   = !empty && frame_ready;
  assign wr_en = push && (!full || pop);
  assign ovf   = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_l[i] <= 1'b0;
        mem_r[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      fcnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_q] <= frame_asm;
        mem_l[wr_q] <= push_r0_load;
        mem_r[wr_q] <= push_r0;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q  <= cnt_q + (PW + 1)'(wr_en)
                      - (PW + 1)'(pop);
      // A new error on the clear edge wins
      err_q  <= (err_q & ~{2{err_clr}})
              | {ovf, perr};
      fcnt_q <= fcnt_q + 8'(pop);
    end
  end

  assign frame_valid   = !empty;
  assign frame_data    = mem_d[rd_q];
  assign frame_r0_load = mem_l[rd_q];
  assign frame_r0      = mem_r[rd_q];
  assign err           = err_q;
  assign frame_cnt     = fcnt_q;

`ifdef LOADER_PIPELINE_EN
  assign ready = idle && (cnt_q <= DEPTH_M1);
`else
  assign ready = idle && empty && !core_busy;
`endif

endmodule

// File: tb/tb_core_insn_frame_loader.sv
// Testbench for core_insn_frame_loader: directed cases plus random
// part streams checked against a queue-based reference model.
module tb_core_insn_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [1:0]  insn_load_counter = '0;
  logic [15:0] insn_data = '0;
  logic        init_r0_en = 1'b0;
  logic [7:0]  init_r0 = '0;
  logic        ready;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [63:0] frame_data;
  logic        frame_r0_load;
  logic [7:0]  frame_r0;
  logic        core_busy = 1'b0;
  logic [1:0]  err;
  logic        err_clr = 1'b0;
  logic [7:0]  frame_cnt;

  int n_chk = 0;
  int n_fail = 0;

  core_insn_frame_loader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .insn_load_counter (insn_load_counter),
    .insn_data         (insn_data),
    .init_r0_en        (init_r0_en),
    .init_r0           (init_r0),
    .ready             (ready),
    .frame_valid       (frame_valid),
    .frame_ready       (frame_ready),
    .frame_data        (frame_data),
    .frame_r0_load     (frame_r0_load),
    .frame_r0          (frame_r0),
    .core_busy         (core_busy),
    .err               (err),
    .err_clr           (err_clr),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [63:0] d;
    bit          l;
    logic [7:0]  r;
  } frm_t;

  localparam int DEPTH = 2;

  frm_t        m_q[$];
  bit          m_load = 0;
  int          m_exp = 0;
  logic [63:0] m_acc = '0;
  bit          m_pend = 0;
  logic [7:0]  m_r0 = '0;
  logic [1:0]  m_err = '0;
  logic [7:0]  m_cnt = '0;

  always @(posedge clk or negedge reset) begin : model
    bit   pu;
    bit   pe;
    bit   po;
    bit   ov;
    bit   was_full;
    frm_t nf;
    if (!reset) begin
      m_load = 0;
      m_exp  = 0;
      m_pend = 0;
      m_err  = '0;
      m_cnt  = '0;
      m_q.delete();
    end else begin
      pu = 0;
      pe = 0;
      ov = 0;
      po = (m_q.size() > 0) && frame_ready;
      was_full = (m_q.size() == DEPTH);
      if (!m_load) begin
        if (start) begin
          if (insn_load_counter == 0) begin
            m_acc[15:0] = insn_data;
            m_pend = init_r0_en;
            if (init_r0_en) m_r0 = init_r0;
            m_load = 1;
            m_exp  = 1;
          end else begin
            pe = 1;
          end
        end
      end else if (start && insn_load_counter == m_exp) begin
        m_acc[m_exp*16 +: 16] = insn_data;
        if (m_exp == 3) begin
          pu = 1;
          m_load = 0;
        end else begin
          m_exp++;
        end
      end else begin
        pe = 1;
        m_load = 0;
        m_pend = 0;
      end
      nf.d = m_acc;
      nf.l = m_pend;
      nf.r = m_r0;
      if (pu) m_pend = 0;
      if (po) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (pu) begin
        if (was_full && !po) ov = 1;
        else m_q.push_back(nf);
      end
      m_err = (m_err & ~{2{err_clr}}) | {ov, pe};
    end
  end

  function automatic bit model_ready();
`ifdef LOADER_PIPELINE_EN
    return !m_load && (m_q.size() <= DEPTH - 1);
`else
    return !m_load && (m_q.size() == 0) && !core_busy;
`endif
  endfunction

  task automatic expect_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_model();
    expect_eq("ready", ready, model_ready());
    expect_eq("valid", frame_valid, m_q.size() > 0);
    expect_eq("err", err, m_err);
    expect_eq("frame_cnt", frame_cnt, m_cnt);
    if (m_q.size() > 0) begin
      expect_eq("frame_data", frame_data, m_q[0].d);
      expect_eq("r0_load", frame_r0_load, m_q[0].l);
      if (m_q[0].l) expect_eq("frame_r0", frame_r0, m_q[0].r);
    end
  endtask

  task automatic check_reset_vals(input string t);
    expect_eq({t, "_valid"}, frame_valid, 0);
    expect_eq({t, "_ready"}, ready, 1);
    expect_eq({t, "_err"}, err, 0);
    expect_eq({t, "_cnt"}, frame_cnt, 0);
    expect_eq({t, "_data"}, frame_data, 0);
    expect_eq({t, "_r0l"}, frame_r0_load, 0);
    expect_eq({t, "_r0"}, frame_r0, 0);
  endtask

  // Called at a negedge: drive, take one edge, check at next negedge
  task automatic step(input bit s, input int c, input logic [15:0] d,
                      input bit ie, input logic [7:0] r);
    start = s;
    insn_load_counter = c[1:0];
    insn_data = d;
    init_r0_en = ie;
    init_r0 = r;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_step();
    step(0, 0, 16'h0, 0, 8'h0);
  endtask

  task automatic send_frame(input logic [63:0] f, input bit ie,
                            input logic [7:0] r);
    for (int p = 0; p < 4; p++) begin
      step(1, p, f[p*16 +: 16], (p == 0) ? ie : 1'b0, r);
    end
  endtask

  task automatic pop_one();
    frame_ready = 1;
    idle_step();
    frame_ready = 0;
  endtask

  task automatic clear_err();
    err_clr = 1;
    idle_step();
    err_clr = 0;
  endtask

  localparam logic [63:0] F1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] F2 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] F3 = 64'hCCCC_BBBB_AAAA_9999;

  initial begin
    logic [7:0] cnt_before;
    reset = 1;
    #1 reset = 0;
    #2 check_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1;
    idle_step();

    // Single frame and latency
    for (int p = 0; p < 3; p++) step(1, p, F1[p*16 +: 16], 0, 0);
    expect_eq("t1_not_yet", frame_valid, 0);
    step(1, 3, F1[48 +: 16], 0, 0);
    expect_eq("t1_valid", frame_valid, 1);
    expect_eq("t1_data", frame_data, 64'h4444_3333_2222_1111);
    expect_eq("t1_r0l", frame_r0_load, 0);
    pop_one();
    expect_eq("t1_cnt", frame_cnt, 1);

    // R0 init on first frame only
    send_frame(F1, 1, 8'hA5);
    send_frame(F2, 0, 8'h00);
    expect_eq("t2_r0l", frame_r0_load, 1);
    expect_eq("t2_r0", frame_r0, 8'hA5);
    pop_one();
    expect_eq("t2_r0l_next", frame_r0_load, 0);
    expect_eq("t2_data_next", frame_data, F2);
    pop_one();

    // Abort after part 1
    step(1, 0, 16'h1234, 0, 0);
    step(1, 1, 16'h5678, 0, 0);
    step(0, 0, 16'h0, 0, 0);
    expect_eq("t3_err", err, 2'b01);
    expect_eq("t3_ready", ready, 1);
    expect_eq("t3_valid", frame_valid, 0);
    send_frame(F3, 0, 0);
    expect_eq("t3_data", frame_data, F3);
    clear_err();
    expect_eq("t3_clr", err, 2'b00);
    pop_one();

    // Overflow with frame_ready low, ready ignored
    send_frame(F1, 0, 0);
    expect_eq("t4_ready0", ready, 0);
    send_frame(F2, 0, 0);
    send_frame(F3, 0, 0);
    expect_eq("t4_ovf", err, 2'b10);
    expect_eq("t4_head1", frame_data, F1);
    pop_one();
    expect_eq("t4_head2", frame_data, F2);
    pop_one();
    expect_eq("t4_empty", frame_valid, 0);
    clear_err();

    // Full FIFO with pop on the final-part edge
    send_frame(F1, 0, 0);
    send_frame(F2, 0, 0);
    cnt_before = m_cnt;
    for (int p = 0; p < 3; p++) step(1, p, F3[p*16 +: 16], 0, 0);
    frame_ready = 1;
    step(1, 3, F3[48 +: 16], 0, 0);
    frame_ready = 0;
    expect_eq("t5_err", err, 2'b00);
    expect_eq("t5_cnt", frame_cnt, cnt_before + 8'd1);
    expect_eq("t5_head", frame_data, F2);
    pop_one();
    expect_eq("t5_tail", frame_data, F3);

    // Async reset mid-load, FIFO non-empty
    for (int p = 0; p < 3; p++) step(1, p, F1[p*16 +: 16], 1, 8'h3C);
    #2 reset = 0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      expect_eq("arst_valid", frame_valid, 0);
    end

    // Random streams
    for (int f = 0; f < 90; f++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        frame_ready = ($urandom % 3) != 0;
        core_busy = $urandom % 2;
        err_clr = ($urandom % 8) == 0;
        idle_step();
      end
      for (int p = 0; p < 4; p++) begin
        bit s;
        int c;
        s = ($urandom % 16) != 0;
        c = (($urandom % 12) == 0) ? $urandom_range(0, 3) : p;
        frame_ready = ($urandom % 3) != 0;
        core_busy = $urandom % 2;
        err_clr = ($urandom % 10) == 0;
        step(s, c, 16'($urandom), $urandom % 2, 8'($urandom));
      end
    end
    frame_ready = 1;
    core_busy = 0;
    err_clr = 0;
    repeat (3) idle_step();
    expect_eq("final_empty", frame_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
